pid_mac_sched: RTL and testbench

- Time-multiplexed PID scheduler for the flight controller.
- On each control tick it runs the pitch, roll and yaw PID laws through one shared signed multiplier, one product per cycle, instead of nine parallel multipliers.
- It keeps the per-axis integrator and previous-error history, and saturates the integrators and outputs.
- It sits between the error stage (target minus fused attitude) and the motor-mix/PWM stage. The main FSM pulses start after the error stage and consumes the corrections on done.

---
 rtl/pid_mac_if.sv | 32 +++
 rtl/pid_mac_sched.sv | 174 +++++++++++++++++
 tb/tb_pid_mac_sched.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pid_mac_if.sv
// Control-tick handshake between the attitude error stage and the PID scheduler.
// The master issues requests and errors/gains; the slave returns corrections.
interface pid_mac_if #(
  parameter int ERR_W = 24,
  parameter int K_W   = 8,
  parameter int OUT_W = 24
);
  logic                    start;
  logic                    clear_int;
  logic signed [ERR_W-1:0] err_pitch;
  logic signed [ERR_W-1:0] err_roll;
  logic signed [ERR_W-1:0] err_yaw;
  logic        [K_W-1:0]   kp;
  logic        [K_W-1:0]   ki;
  logic        [K_W-1:0]   kd;
  logic                    busy;
  logic                    done;
  logic signed [OUT_W-1:0] corr_pitch;
  logic signed [OUT_W-1:0] corr_roll;
  logic signed [OUT_W-1:0] corr_yaw;
  logic                    overrun;

  modport master (
    output start, clear_int, err_pitch, err_roll, err_yaw, kp, ki, kd,
    input  busy, done, corr_pitch, corr_roll, corr_yaw, overrun
  );

  modport slave (
    input  start, clear_int, err_pitch, err_roll, err_yaw, kp, ki, kd,
    output busy, done, corr_pitch, corr_roll, corr_yaw, overrun
  );
endinterface

// File: rtl/pid_mac_sched.sv
// Time-multiplexed pitch/roll/yaw PID: one shared signed multiplier, one product
// per cycle, with per-axis saturating integrators and previous-error history.
module pid_mac_sched #(
  parameter int ERR_W   = 24,
  parameter int K_W     = 8,
  parameter int OUT_W   = 24,
  parameter int I_LIM   = 1000000,
  parameter int OUT_LIM = 8388607
) (
  input logic     clk,
  input logic     rst_n,
  pid_mac_if.slave bus
);

  localparam int IW    = ERR_W + 2;
  localparam int DW    = ERR_W + 1;
  localparam int GW    = K_W + 1;
  localparam int PW    = IW + GW;
  localparam int ACC_W = 36;

  localparam logic signed [IW-1:0]    I_MAX = IW'(I_LIM);
  localparam logic signed [IW-1:0]    I_MIN = -I_MAX;
  localparam logic signed [ACC_W-1:0] O_MAX = ACC_W'(OUT_LIM);
  localparam logic signed [ACC_W-1:0] O_MIN = -O_MAX;

  typedef enum logic [2:0] {IDLE, PREP, MUL_P, MUL_I, MUL_D, WRITE, DONE} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              axis;
  logic signed [ERR_W-1:0] err_q [3];
  logic [K_W-1:0]          kp_q, ki_q, kd_q;
  logic signed [IW-1:0]    integ [3];
  logic signed [ERR_W-1:0] prev [3];
  logic signed [IW-1:0]    inew_q;
  logic signed [DW-1:0]    deriv_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [OUT_W-1:0] corr [3];
  logic                    clr_pend, overrun_q;
  logic                    busy_c, done_c, accept;

  logic signed [ERR_W-1:0] err_cur;
  logic signed [IW-1:0]    inew_c;
  logic signed [DW-1:0]    deriv_c;
  logic signed [IW-1:0]    mul_a;
  logic signed [GW-1:0]    mul_b;
  logic signed [PW-1:0]    prod;

  // Symmetric clamps: the most negative raw value lands on -LIM, not -LIM-1.
  function automatic logic signed [IW-1:0] sat_int(input logic signed [IW-1:0] v);
    if (v > I_MAX)      return I_MAX;
    else if (v < I_MIN) return I_MIN;
    else                return v;
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] c;
    if (v > O_MAX)      c = O_MAX;
    else if (v < O_MIN) c = O_MIN;
    else                c = v;
    return OUT_W'(c);
  endfunction

  assign err_cur = err_q[axis];
  assign inew_c  = sat_int(integ[axis] + IW'(err_cur));
  assign deriv_c = DW'(err_cur) - DW'(prev[axis]);

  // Single multiplier; operand pair chosen by which term is being accumulated.
  always_comb begin
    mul_a = IW'(err_cur);
    mul_b = $signed({1'b0, kp_q});
    case (state)
      MUL_I: begin
        mul_a = inew_q;
        mul_b = $signed({1'b0, ki_q});
      end
      MUL_D: begin
        mul_a = IW'(deriv_q);
        mul_b = $signed({1'b0, kd_q});
      end
      default: ;
    endcase
  end

  assign prod = mul_a * mul_b;

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b1;
    done_c    = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) begin
          state_nxt = PREP;
          accept    = 1'b1;
        end
      end
      PREP:    state_nxt = MUL_P;
      MUL_P:   state_nxt = MUL_I;
      MUL_I:   state_nxt = MUL_D;
      MUL_D:   state_nxt = WRITE;
      WRITE:   state_nxt = (axis == 2'd2) ? DONE : PREP;
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      axis      <= 2'd0;
      overrun_q <= 1'b0;
      clr_pend  <= 1'b0;
      acc       <= '0;
      for (int i = 0; i < 3; i++) begin
        integ[i] <= '0;
        prev[i]  <= '0;
        corr[i]  <= '0;
      end
    end else begin
      state <= state_nxt;
      if (bus.start && state != IDLE) overrun_q <= 1'b1;
      // A clear requested mid-run waits for IDLE so the running tick keeps its history.
      if (state == IDLE && (bus.clear_int || clr_pend)) begin
        clr_pend <= 1'b0;
        for (int i = 0; i < 3; i++) begin
          integ[i] <= '0;
          prev[i]  <= '0;
        end
      end else if (bus.clear_int) begin
        clr_pend <= 1'b1;
      end
      case (state)
        IDLE:                if (accept) axis <= 2'd0;
        PREP:                acc <= '0;
        MUL_P, MUL_I, MUL_D: acc <= acc + ACC_W'(prod);
        WRITE: begin
          corr[axis]  <= sat_out(acc);
          integ[axis] <= inew_q;
          prev[axis]  <= err_cur;
          if (axis != 2'd2) axis <= axis + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      err_q[0] <= bus.err_pitch;
      err_q[1] <= bus.err_roll;
      err_q[2] <= bus.err_yaw;
      kp_q     <= bus.kp;
      ki_q     <= bus.ki;
      kd_q     <= bus.kd;
    end
    if (state == PREP) begin
      inew_q  <= inew_c;
      deriv_q <= deriv_c;
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.corr_pitch = corr[0];
  assign bus.corr_roll  = corr[1];
  assign bus.corr_yaw   = corr[2];
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_pid_mac_sched.sv
// Scoreboard bench for pid_mac_sched: runs push hand-computed corrections,
// a negedge monitor pops and compares them on every done pulse.
module tb_pid_mac_sched;
  localparam int ERR_W = 24;
  localparam int K_W   = 8;
  localparam int OUT_W = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pid_mac_if #(.ERR_W(ERR_W), .K_W(K_W), .OUT_W(OUT_W)) bus ();

  pid_mac_sched #(.ERR_W(ERR_W), .K_W(K_W), .OUT_W(OUT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int p;
    int r;
    int y;
    int ovr;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_done = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        e = sb.pop_front();
        chk("corr_pitch", int'(bus.corr_pitch), e.p);
        chk("corr_roll",  int'(bus.corr_roll),  e.r);
        chk("corr_yaw",   int'(bus.corr_yaw),   e.y);
        chk("overrun",    int'(bus.overrun),    e.ovr);
      end
    end
  end

  task automatic set_in(input int ep, input int er, input int ey,
                        input int p, input int i, input int d);
    bus.err_pitch = ERR_W'(ep);
    bus.err_roll  = ERR_W'(er);
    bus.err_yaw   = ERR_W'(ey);
    bus.kp        = K_W'(p);
    bus.ki        = K_W'(i);
    bus.kd        = K_W'(d);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clear_int = 1'b1;
    @(negedge clk);
    bus.clear_int = 1'b0;
  endtask

  // Waits for done; lat is the number of negedges expected to pass before it.
  task automatic wait_done(input int lat);
    int  n    = 0;
    bit  seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      n++;
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL done_timeout: got no done within 40 cycles expected done");
    end else begin
      chk("done_latency", n, lat);
      @(negedge clk);
      chk("done_width", int'(bus.done), 0);
      chk("busy_after_done", int'(bus.busy), 0);
    end
  endtask

  task automatic run(input int ep, input int er, input int ey,
                     input int p, input int i, input int d,
                     input int xp, input int xr, input int xy, input int xo,
                     input bit clr = 1'b0, input bit mid_clr = 1'b0);
    @(negedge clk);
    set_in(ep, er, ey, p, i, d);
    bus.start     = 1'b1;
    bus.clear_int = clr;
    sb.push_back('{xp, xr, xy, xo});
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.clear_int = 1'b0;
    set_in(~ep, ~er, ~ey, ~p, ~i, ~d);
    chk("busy_after_start", int'(bus.busy), 1);
    if (mid_clr) begin
      @(negedge clk);
      bus.clear_int = 1'b1;
      @(negedge clk);
      bus.clear_int = 1'b0;
      wait_done(13);
    end else begin
      wait_done(15);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2 ms");
    $fatal(1);
  end

  initial begin
    int done_before;
    bus.start     = 1'b0;
    bus.clear_int = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_busy",    int'(bus.busy),       0);
    chk("rst_done",    int'(bus.done),       0);
    chk("rst_overrun", int'(bus.overrun),    0);
    chk("rst_corr_p",  int'(bus.corr_pitch), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Proportional only
    run(10, -3, 0, 100, 0, 0, 1000, -300, 0, 0);

    // Integral accumulation then clear
    pulse_clear();
    run(5, 0, 0, 0, 1, 0, 5, 0, 0, 0);
    run(5, 0, 0, 0, 1, 0, 10, 0, 0, 0);
    run(5, 0, 0, 0, 1, 0, 15, 0, 0, 0);
    pulse_clear();
    run(5, 0, 0, 0, 1, 0, 5, 0, 0, 0);

    // Derivative
    pulse_clear();
    run(0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    run(0, 7, 0, 0, 0, 2, 0, 14, 0, 0);
    run(0, 7, 0, 0, 0, 2, 0, 0, 0, 0);

    // Integrator and output saturation
    pulse_clear();
    run(0, 0, 600000, 0, 1, 0, 0, 0, 600000, 0);
    run(0, 0, 600000, 0, 1, 0, 0, 0, 1000000, 0);
    pulse_clear();
    run(8000000, 0, 0, 255, 0, 0, 8388607, 0, 0, 0);
    run(-8000000, 0, 0, 255, 0, 0, -8388607, 0, 0, 0);

    // All three terms with per-axis history
    pulse_clear();
    run(100, -50, 7, 3, 2, 1, 600, -300, 42, 0);
    run(40, -10, 7, 3, 2, 1, 340, -110, 49, 0);

    // Overrun: second start 4 cycles into a run with different inputs
    pulse_clear();
    done_before = n_done;
    @(negedge clk);
    set_in(10, -3, 0, 100, 0, 0);
    bus.start = 1'b1;
    sb.push_back('{1000, -300, 0, 1});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    set_in(99, 99, 99, 1, 1, 1);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(11);
    repeat (20) @(negedge clk);
    chk("single_done", n_done, done_before + 1);
    chk("overrun_sticky", int'(bus.overrun), 1);

    // Coincident clear and start: computation sees zero history
    run(5, 0, 0, 0, 1, 0, 5, 0, 0, 1, 1'b1, 1'b0);
    // Clear during a run keeps results, applies afterwards
    run(5, 0, 0, 0, 1, 0, 10, 0, 0, 1, 1'b0, 1'b1);
    run(5, 0, 0, 0, 1, 0, 5, 0, 0, 1);

    // Reset mid-run
    @(negedge clk);
    set_in(5, 0, 0, 0, 1, 0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",    int'(bus.busy),       0);
    chk("midrst_done",    int'(bus.done),       0);
    chk("midrst_corr_p",  int'(bus.corr_pitch), 0);
    chk("midrst_overrun", int'(bus.overrun),    0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run(5, 0, 0, 0, 1, 0, 5, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
